// File: rtl/axis_slave_pkt_rx_if.sv
// Stream-in / replay-out bundle for axis_slave_pkt_rx.
interface axis_slave_pkt_rx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 5
);
  logic                  s_axis_tvalid;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tlast;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_last;
  logic                  rd_ready;
  logic [LEN_W-1:0]      pkt_len;
  logic                  pkt_done;
  logic                  overflow;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, rd_ready,
    output s_axis_tready, dout, dout_valid, dout_last, pkt_len, pkt_done, overflow
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, rd_ready,
    input  s_axis_tready, dout, dout_valid, dout_last, pkt_len, pkt_done, overflow
  );
endinterface

// File: rtl/axis_slave_pkt_rx.sv
// Single-packet AXI4-Stream receiver: buffers one packet, then replays it
// on a valid/ready read port. Oversized packets are swallowed and flagged.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | one-cycle settle after reset, tready held low
// S_RECV  | accepting beats into the buffer
// S_DROP  | packet outgrew the buffer, discarding beats until tlast
// S_DRAIN | replaying the stored packet, upstream back-pressured
module axis_slave_pkt_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 4,
  parameter int LEN_W      = 5
) (
  input  logic                 s_axis_clk,
  input  logic                 s_axis_rstn,
  axis_slave_pkt_rx_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP, S_DRAIN} state_t;

  state_t                r_state;
  logic [LEN_W-1:0]      r_wr_cnt;
  logic [LEN_W-1:0]      r_rd_cnt;
  logic [LEN_W-1:0]      r_pkt_len;
  logic                  r_pkt_done;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_tready;
  logic                  w_dout_valid;
  logic                  w_dout_last;
  logic [DATA_WIDTH-1:0] w_dout;
  logic                  w_accept;
  logic                  w_read;

  // Handshake and read-port outputs decode straight from state and counters.
  always_comb begin
    w_tready     = (r_state == S_RECV) || (r_state == S_DROP);
    w_dout_valid = (r_state == S_DRAIN);
    w_dout_last  = w_dout_valid && (r_rd_cnt == r_pkt_len - LEN_W'(1));
    w_dout       = w_dout_valid ? r_mem[r_rd_cnt[ADDR_W-1:0]] : '0;
    w_accept     = bus.s_axis_tvalid && w_tready;
    w_read       = w_dout_valid && bus.rd_ready;
  end

  // Buffer write; contents need no reset since the counters gate every read.
  always_ff @(posedge s_axis_clk) begin
    if (w_accept && (r_state == S_RECV)) begin
      r_mem[r_wr_cnt[ADDR_W-1:0]] <= bus.s_axis_tdata;
    end
  end

  // Packet sequencing: receive, drop on overflow, replay, then re-arm.
  always_ff @(posedge s_axis_clk or negedge s_axis_rstn) begin
    if (!s_axis_rstn) begin
      r_state    <= S_IDLE;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_pkt_len  <= '0;
      r_pkt_done <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      r_overflow <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_RECV;
        S_RECV: begin
          if (w_accept) begin
            r_wr_cnt <= r_wr_cnt + LEN_W'(1);
            if (bus.s_axis_tlast) begin
              r_pkt_len <= r_wr_cnt + LEN_W'(1);
              r_rd_cnt  <= '0;
              r_state   <= S_DRAIN;
            end else if (r_wr_cnt == LEN_W'(DEPTH - 1)) begin
              // Buffer is full and more is coming: the packet cannot fit.
              r_state <= S_DROP;
            end
          end
        end
        S_DROP: begin
          if (w_accept && bus.s_axis_tlast) begin
            r_overflow <= 1'b1;
            r_wr_cnt   <= '0;
            r_state    <= S_RECV;
          end
        end
        S_DRAIN: begin
          if (w_read) begin
            r_rd_cnt <= r_rd_cnt + LEN_W'(1);
            if (w_dout_last) begin
              r_pkt_done <= 1'b1;
              r_wr_cnt   <= '0;
              r_rd_cnt   <= '0;
              r_state    <= S_RECV;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.s_axis_tready = w_tready;
  assign bus.dout_valid    = w_dout_valid;
  assign bus.dout_last     = w_dout_last;
  assign bus.dout          = w_dout;
  assign bus.pkt_len       = r_pkt_len;
  assign bus.pkt_done      = r_pkt_done;
  assign bus.overflow      = r_overflow;
endmodule

// File: tb/tb_axis_slave_pkt_rx.sv
// Bench for axis_slave_pkt_rx: queue-based packet model checked every cycle,
// plus literal expectations per directed scenario.
module tb_axis_slave_pkt_rx;
  localparam int DEPTH = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axis_slave_pkt_rx_if #(.DATA_WIDTH(8), .LEN_W(5)) bus ();

  axis_slave_pkt_rx #(.DATA_WIDTH(8), .ADDR_W(4), .LEN_W(5)) dut (
    .s_axis_clk  (clk),
    .s_axis_rstn (rstn),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bytes gathered for the current packet, bytes awaiting replay,
  // and a log of every byte the consumer has taken.
  logic [7:0] m_q_rx[$];
  logic [7:0] m_q_out[$];
  logic [7:0] m_log[$];
  logic [7:0] pkt[$];
  bit         m_startup = 1'b1;
  bit         m_drop    = 1'b0;
  bit         m_done    = 1'b0;
  bit         m_ovf     = 1'b0;
  int         m_len     = 0;
  int         n_done_seen = 0;
  int         n_ovf_seen  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_tready();
    return rstn && !m_startup && (m_q_out.size() == 0);
  endfunction

  // Model update: one step per clock, from the inputs the DUT sees.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_q_rx.delete();
      m_q_out.delete();
      m_startup = 1'b1;
      m_drop    = 1'b0;
      m_done    = 1'b0;
      m_ovf     = 1'b0;
      m_len     = 0;
    end else begin
      m_done = 1'b0;
      m_ovf  = 1'b0;
      if (m_startup) begin
        m_startup = 1'b0;
      end else if (m_q_out.size() != 0) begin
        if (bus.rd_ready) begin
          m_log.push_back(m_q_out.pop_front());
          if (m_q_out.size() == 0) m_done = 1'b1;
        end
      end else if (bus.s_axis_tvalid) begin
        if (m_drop) begin
          if (bus.s_axis_tlast) begin
            m_drop = 1'b0;
            m_ovf  = 1'b1;
          end
        end else begin
          m_q_rx.push_back(bus.s_axis_tdata);
          if (bus.s_axis_tlast) begin
            m_q_out = m_q_rx;
            m_len   = m_q_rx.size();
            m_q_rx.delete();
          end else if (m_q_rx.size() == DEPTH) begin
            m_drop = 1'b1;
            m_q_rx.delete();
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [7:0] exp_dout;
    exp_dout = 8'h00;
    if (m_q_out.size() != 0) exp_dout = m_q_out[0];
    chk("tready",     bus.s_axis_tready, m_tready());
    chk("dout_valid", bus.dout_valid,    m_q_out.size() != 0);
    chk("dout",       bus.dout,          exp_dout);
    chk("dout_last",  bus.dout_last,     m_q_out.size() == 1);
    chk("pkt_len",    bus.pkt_len,       m_len);
    chk("pkt_done",   bus.pkt_done,      m_done);
    chk("overflow",   bus.overflow,      m_ovf);
    if (bus.pkt_done === 1'b1) n_done_seen++;
    if (bus.overflow === 1'b1) n_ovf_seen++;
  end

  // Send the bytes in pkt, tlast on the final one; optional random gaps.
  task automatic send_pkt(input bit gaps);
    bit acc;
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.s_axis_tvalid = 1'b0;
          @(negedge clk);
        end
      end
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = pkt[i];
      bus.s_axis_tlast  = (i == pkt.size() - 1);
      acc = 1'b0;
      for (int t = 0; t < 60 && !acc; t++) begin
        acc = m_tready();
        @(negedge clk);
      end
      if (!acc) chk("beat_accept_timeout", 32'd0, 32'd1);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tdata  = 8'h00;
  endtask

  // Consume the replay, optionally stalling at random.
  task automatic drain(input bit stall);
    int t;
    t = 0;
    while (m_q_out.size() != 0 && t < 300) begin
      bus.rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      t++;
    end
    if (m_q_out.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
    bus.rd_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_len"}, m_log.size(), pkt.size());
    for (int i = 0; i < pkt.size() && i < m_log.size(); i++)
      chk({nm, "_byte"}, m_log[i], pkt[i]);
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = 8'h00;
    bus.s_axis_tlast  = 1'b0;
    bus.rd_ready      = 1'b1;

    // 1: reset hold and release
    repeat (5) begin
      @(negedge clk);
      chk("rst_tready", bus.s_axis_tready, 1'b0);
    end
    #2 rstn = 1'b1;
    #1 chk("tready_after_release", bus.s_axis_tready, 1'b0);
    @(negedge clk);
    chk("tready_2nd_cycle", bus.s_axis_tready, 1'b1);

    // 2: basic 4-byte packet
    pkt.delete();
    pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33); pkt.push_back(8'h44);
    m_log.delete();
    n_done_seen = 0;
    send_pkt(1'b0);
    drain(1'b0);
    chk_log("t2_replay");
    chk("t2_pkt_len", bus.pkt_len, 5'd4);
    chk("t2_done_count", n_done_seen, 1);

    // 3: same packet, input gaps and read stalls
    m_log.delete();
    send_pkt(1'b1);
    drain(1'b1);
    chk_log("t3_replay");
    chk("t3_pkt_len", bus.pkt_len, 5'd4);

    // 4: exactly full buffer
    pkt.delete();
    for (int i = 0; i < 16; i++) pkt.push_back(8'(i));
    m_log.delete();
    n_ovf_seen = 0;
    send_pkt(1'b0);
    drain(1'b0);
    chk_log("t4_replay");
    chk("t4_pkt_len", bus.pkt_len, 5'd16);
    chk("t4_overflow_count", n_ovf_seen, 0);

    // 5: oversized packet dropped, next one replays
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(8'(8'h80 + i));
    m_log.delete();
    send_pkt(1'b0);
    repeat (2) @(negedge clk);
    chk("t5_overflow_count", n_ovf_seen, 1);
    chk("t5_no_replay", m_log.size(), 0);
    chk("t5_pkt_len_held", bus.pkt_len, 5'd16);
    pkt.delete();
    pkt.push_back(8'hA5); pkt.push_back(8'h5A);
    send_pkt(1'b0);
    drain(1'b0);
    chk_log("t5_replay");
    chk("t5_pkt_len", bus.pkt_len, 5'd2);

    // 6: reset in the middle of a drain
    pkt.delete();
    pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03); pkt.push_back(8'h04);
    m_log.delete();
    bus.rd_ready = 1'b0;
    send_pkt(1'b0);
    bus.rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_reads_before_rst", m_log.size(), 2);
    #2 rstn = 1'b0;
    bus.rd_ready = 1'b0;
    #1 chk("t6_valid_drop", bus.dout_valid, 1'b0);
    chk("t6_tready_drop", bus.s_axis_tready, 1'b0);
    chk("t6_pkt_len_rst", bus.pkt_len, 5'd0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    bus.rd_ready = 1'b1;
    @(negedge clk);
    pkt.delete();
    pkt.push_back(8'h01); pkt.push_back(8'h02);
    m_log.delete();
    send_pkt(1'b0);
    drain(1'b0);
    chk_log("t6_replay");
    chk("t6_pkt_len", bus.pkt_len, 5'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
